// File: rtl/screen_pkg.sv
// Shared fetch FSM state type and derived line-buffer geometry for the screen fetch path.
// The localparams describe the default build; modules re-derive them from their own parameters.
package screen_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} fetch_state_e;

  function automatic int unsigned calc_bin_words(input int unsigned data_width,
                                                 input int unsigned bpx);
    return 512 >> ($clog2(data_width) + bpx);
  endfunction

  function automatic int unsigned calc_pixels_per_word(input int unsigned data_width,
                                                       input int unsigned bpx);
    return data_width << bpx;
  endfunction

  localparam int unsigned HEX_WORDS       = 2;
  localparam int unsigned BIN_WORDS       = calc_bin_words(16, 4);
  localparam int unsigned LINE_WORDS      = BIN_WORDS + HEX_WORDS;
  localparam int unsigned PIXELS_PER_WORD = calc_pixels_per_word(16, 4);

endpackage

// File: rtl/line_buffer_pp.sv
// Ping-pong line buffer: two banks of Depth words, one write port, one asynchronous read port.
module line_buffer_pp #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 4,
  localparam int unsigned IdxW     = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic                 wr_bank_i,
  input  logic [IdxW-1:0]      wr_idx_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_bank_i,
  input  logic [IdxW-1:0]      rd_idx_i,
  output logic [DataWidth-1:0] rd_data_o
);

  localparam int unsigned Words = 2 * Depth;
  localparam int unsigned AddrW = $clog2(Words);

  logic [DataWidth-1:0] mem_q [Words];
  logic [AddrW-1:0]     wr_addr;
  logic [AddrW-1:0]     rd_addr;

  assign wr_addr = AddrW'(wr_bank_i ? Depth + 32'(wr_idx_i) : 32'(wr_idx_i));
  assign rd_addr = AddrW'(rd_bank_i ? Depth + 32'(rd_idx_i) : 32'(rd_idx_i));

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr];

endmodule

// File: rtl/screen_fetch.sv
// Prefetches the next scan line's screen words into a ping-pong buffer and serves the word
// under the beam. Define SCREEN_FETCH_STATS_EN to add a saturating underrun_count output.
module screen_fetch
  import screen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH              = 16,
  parameter int unsigned BITS_PER_MEMORY_PIXEL_X = 4,
  parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = 5,
  parameter int unsigned HEX_START_X             = 512,
  parameter int unsigned HEX_DIGIT_HEIGHT        = 32,
  parameter int unsigned V_VISIBLE               = 480,
  parameter int unsigned RAM_LATENCY             = 1
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic [DATA_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] word_value,
  output logic                  word_valid
`ifdef SCREEN_FETCH_STATS_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int unsigned BinWords      = calc_bin_words(DATA_WIDTH, BITS_PER_MEMORY_PIXEL_X);
  localparam int unsigned LineWords     = BinWords + HEX_WORDS;
  localparam int unsigned PixPerWord    = calc_pixels_per_word(DATA_WIDTH,
                                                               BITS_PER_MEMORY_PIXEL_X);
  localparam int unsigned HexPixPerWord = DATA_WIDTH / 4 * 16;
  localparam int unsigned IdxW          = $clog2(LineWords);
  localparam int unsigned DrainW        = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(LineWords - 1);
  localparam logic [DrainW-1:0] LastDrain = DrainW'(RAM_LATENCY - 1);

  fetch_state_e      state_q;
  logic [IdxW-1:0]   idx_q;
  logic [9:0]        line_q;
  logic [DrainW-1:0] drain_q;
  logic [9:0]        py_q;
  logic              fill_bank_q;
  logic [1:0]        done_q;
  logic              pipe_vld_q [RAM_LATENCY];
  logic [IdxW-1:0]   pipe_idx_q [RAM_LATENCY];

  logic              new_line;
  logic              disp_bank;
  logic [10:0]       y_inc;
  logic [9:0]        line_next;
  logic [31:0]       px;
  logic [31:0]       ri;
  logic [IdxW-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  function automatic logic [DATA_WIDTH-1:0] fetch_addr(input logic [9:0]      line,
                                                      input logic [IdxW-1:0] idx);
    logic [31:0] l;
    logic [31:0] i;
    logic [31:0] a;
    l = 32'(line);
    i = 32'(idx);
    if (i < BinWords) a = (l >> BITS_PER_MEMORY_PIXEL_Y) * BinWords + i;
    else              a = (l / HEX_DIGIT_HEIGHT) * HEX_WORDS + (i - BinWords);
    return DATA_WIDTH'(a);
  endfunction

  assign new_line  = (pixel_y != py_q);
  assign disp_bank = ~fill_bank_q;
  assign y_inc     = {1'b0, pixel_y} + 11'd1;
  assign line_next = (y_inc >= 11'(V_VISIBLE)) ? 10'd0 : y_inc[9:0];

  // A new line always wins: it swaps banks and restarts the fetch, aborting any in flight.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      ram_re      <= 1'b0;
      ram_addr    <= '0;
      idx_q       <= '0;
      line_q      <= '0;
      drain_q     <= '0;
      py_q        <= '0;
      fill_bank_q <= 1'b0;
      done_q      <= '0;
    end else begin
      py_q <= pixel_y;
      if (new_line) begin
        fill_bank_q       <= ~fill_bank_q;
        done_q[disp_bank] <= 1'b0;
        line_q            <= line_next;
        idx_q             <= '0;
        ram_addr          <= fetch_addr(line_next, '0);
        ram_re            <= 1'b1;
        state_q           <= StIssue;
      end else begin
        case (state_q)
          StIdle: begin
          end
          StIssue: begin
            if (idx_q == LastIdx) begin
              ram_re  <= 1'b0;
              drain_q <= '0;
              state_q <= StDrain;
            end else begin
              idx_q    <= idx_q + IdxW'(1);
              ram_addr <= fetch_addr(line_q, idx_q + IdxW'(1));
            end
          end
          StDrain: begin
            if (drain_q == LastDrain) begin
              done_q[fill_bank_q] <= 1'b1;
              state_q             <= StIdle;
            end else begin
              drain_q <= drain_q + DrainW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Request index travels alongside the RAM so data lands RAM_LATENCY cycles after its request.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < RAM_LATENCY; k++) begin
        pipe_vld_q[k] <= 1'b0;
        pipe_idx_q[k] <= '0;
      end
    end else if (new_line) begin
      for (int k = 0; k < RAM_LATENCY; k++) begin
        pipe_vld_q[k] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0] <= ram_re;
      pipe_idx_q[0] <= idx_q;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_idx_q[k] <= pipe_idx_q[k-1];
      end
    end
  end

  always_comb begin
    px = 32'(pixel_x);
    if (px < HEX_START_X) ri = px / PixPerWord;
    else                  ri = BinWords + (px - HEX_START_X) / HexPixPerWord;
    if (ri > LineWords - 1) ri = LineWords - 1;
    rd_idx = IdxW'(ri);
  end

  line_buffer_pp #(
    .DataWidth (DATA_WIDTH),
    .Depth     (LineWords)
  ) u_line_buffer (
    .clk_i     (CLK_50),
    .wr_en_i   (pipe_vld_q[RAM_LATENCY-1]),
    .wr_bank_i (fill_bank_q),
    .wr_idx_i  (pipe_idx_q[RAM_LATENCY-1]),
    .wr_data_i (ram_rdata),
    .rd_bank_i (disp_bank),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      word_value <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= done_q[disp_bank];
      word_value <= done_q[disp_bank] ? rd_data : '0;
    end
  end

`ifdef SCREEN_FETCH_STATS_EN
  logic [15:0] underrun_q;

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      underrun_q <= '0;
    end else if (new_line && (state_q != StIdle) && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_screen_fetch.sv
// Scoreboard bench: two instances (RAM latency 1 and 3) share directed pixel stimulus.
module tb_screen_fetch;
  import screen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] ram_addr1, ram_rdata1, word_value1;
  logic        ram_re1, word_valid1;
  logic [15:0] ram_addr3, ram_rdata3, word_value3;
  logic        ram_re3, word_valid3;
  logic [15:0] s3a, s3b;
`ifdef SCREEN_FETCH_STATS_EN
  logic [15:0] underrun1, underrun3;
`endif

  int total = 0;
  int bad   = 0;
  logic        word_chk;
  logic [15:0] aq1 [$];
  logic [15:0] aq3 [$];
  logic [16:0] wq  [$];
  logic [15:0] ea;
  logic [16:0] ew;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  screen_fetch #(.RAM_LATENCY(1)) dut_l1 (
    .CLK_50     (clk),
    .resetN     (rst_n),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .ram_addr   (ram_addr1),
    .ram_re     (ram_re1),
    .ram_rdata  (ram_rdata1),
    .word_value (word_value1),
    .word_valid (word_valid1)
`ifdef SCREEN_FETCH_STATS_EN
    ,
    .underrun_count (underrun1)
`endif
  );

  screen_fetch #(.RAM_LATENCY(3)) dut_l3 (
    .CLK_50     (clk),
    .resetN     (rst_n),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .ram_addr   (ram_addr3),
    .ram_re     (ram_re3),
    .ram_rdata  (ram_rdata3),
    .word_value (word_value3),
    .word_valid (word_valid3)
`ifdef SCREEN_FETCH_STATS_EN
    ,
    .underrun_count (underrun3)
`endif
  );

  // RAM models: word[k] = 0xA000 + k, delivered 1 or 3 cycles after the address.
  always @(posedge clk) ram_rdata1 <= 16'hA000 + ram_addr1;
  always @(posedge clk) begin
    s3a        <= 16'hA000 + ram_addr3;
    s3b        <= s3a;
    ram_rdata3 <= s3b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected addresses on every live request and expected words on demand.
  always @(posedge clk) begin
    #1;
    if (ram_re1) begin
      if (aq1.size() == 0) check("l1 ram_re unexpected", 32'(ram_re1), 32'd0);
      else begin
        ea = aq1.pop_front();
        check("l1 ram_addr", 32'(ram_addr1), 32'(ea));
      end
    end
    if (ram_re3) begin
      if (aq3.size() == 0) check("l3 ram_re unexpected", 32'(ram_re3), 32'd0);
      else begin
        ea = aq3.pop_front();
        check("l3 ram_addr", 32'(ram_addr3), 32'(ea));
      end
    end
    if (word_chk && (wq.size() != 0)) begin
      ew = wq.pop_front();
      check("l1 word_value", 32'(word_value1), 32'(ew[15:0]));
      check("l1 word_valid", 32'(word_valid1), 32'(ew[16]));
      check("l3 word_value", 32'(word_value3), 32'(ew[15:0]));
      check("l3 word_valid", 32'(word_valid3), 32'(ew[16]));
    end
  end

  task automatic push_addr(input logic [15:0] a);
    aq1.push_back(a);
    aq3.push_back(a);
  endtask

  task automatic push_line(input logic [15:0] a0, input logic [15:0] a1);
    push_addr(a0); push_addr(a1); push_addr(a0); push_addr(a1);
  endtask

  task automatic step_line(input logic [9:0] y, input logic [15:0] a0, input logic [15:0] a1);
    push_line(a0, a1);
    @(negedge clk);
    pixel_y = y;
    repeat (12) @(negedge clk);
  endtask

  task automatic expect_word(input logic [9:0] x, input logic [15:0] v, input logic vld);
    @(negedge clk);
    pixel_x  = x;
    wq.push_back({vld, v});
    word_chk = 1'b1;
    @(negedge clk);
    word_chk = 1'b0;
  endtask

  task automatic check_state(input string name, input fetch_state_e act, input fetch_state_e exp);
    check(name, 32'(act), 32'(exp));
  endtask

  initial begin
    rst_n    = 1'b0;
    pixel_x  = '0;
    pixel_y  = '0;
    word_chk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst l1 ram_re", 32'(ram_re1), 32'd0);
    check("rst l1 ram_addr", 32'(ram_addr1), 32'd0);
    check("rst l1 word_value", 32'(word_value1), 32'd0);
    check("rst l1 word_valid", 32'(word_valid1), 32'd0);
    check("rst l3 ram_re", 32'(ram_re3), 32'd0);
    check("rst l3 word_valid", 32'(word_valid3), 32'd0);
    check_state("rst l1 state", dut_l1.state_q, StIdle);
`ifdef SCREEN_FETCH_STATS_EN
    check("rst l1 underrun", 32'(underrun1), 32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Line 2 fetch: four requests, then drain of RAM_LATENCY cycles.
    push_line(16'd0, 16'd1);
    pixel_y = 10'd1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_state("l1 drain", dut_l1.state_q, StDrain);
    check_state("l3 drain", dut_l3.state_q, StDrain);
    @(posedge clk); #1;
    check_state("l1 idle", dut_l1.state_q, StIdle);
    check_state("l3 drain2", dut_l3.state_q, StDrain);
    repeat (2) @(posedge clk); #1;
    check_state("l3 idle", dut_l3.state_q, StIdle);
    repeat (4) @(negedge clk);
    expect_word(10'd300, 16'h0000, 1'b0);
    expect_word(10'd600, 16'h0000, 1'b0);

    // Line 65 lands in addresses 4,5; shown after the following swap.
    step_line(10'd63, 16'd4, 16'd5);
    step_line(10'd64, 16'd4, 16'd5);
    step_line(10'd65, 16'd4, 16'd5);
    expect_word(10'd300,  16'hA005, 1'b1);
    expect_word(10'd0,    16'hA004, 1'b1);
    expect_word(10'd511,  16'hA005, 1'b1);
    expect_word(10'd512,  16'hA004, 1'b1);
    expect_word(10'd600,  16'hA005, 1'b1);
    expect_word(10'd1023, 16'hA005, 1'b1);

    // Last visible line wraps to line 0.
    step_line(10'd479, 16'd0, 16'd1);
    expect_word(10'd100, 16'hA004, 1'b1);
    step_line(10'd0, 16'd0, 16'd1);
    expect_word(10'd100, 16'hA000, 1'b1);
    expect_word(10'd700, 16'hA001, 1'b1);

    // Abort: line 127 fetch interrupted after two requests by line 128.
    push_addr(16'd6); push_addr(16'd7);
    push_line(16'd8, 16'd9);
    @(negedge clk) pixel_y = 10'd126;
    @(negedge clk);
    @(negedge clk) pixel_y = 10'd127;
    repeat (12) @(negedge clk);
    expect_word(10'd300, 16'h0000, 1'b0);
    expect_word(10'd800, 16'h0000, 1'b0);
`ifdef SCREEN_FETCH_STATS_EN
    check("l1 underrun", 32'(underrun1), 32'd1);
    check("l3 underrun", 32'(underrun3), 32'd1);
`endif
    step_line(10'd128, 16'd8, 16'd9);
    expect_word(10'd300, 16'hA009, 1'b1);
    expect_word(10'd520, 16'hA008, 1'b1);

    // Reset mid-issue after two requests.
    push_addr(16'd12); push_addr(16'd13);
    @(negedge clk) pixel_y = 10'd200;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid rst l1 ram_re", 32'(ram_re1), 32'd0);
    check("mid rst l3 ram_re", 32'(ram_re3), 32'd0);
    check("mid rst l1 word_valid", 32'(word_valid1), 32'd0);
    check("mid rst l3 ram_addr", 32'(ram_addr3), 32'd0);
    check_state("mid rst l1 state", dut_l1.state_q, StIdle);
    check_state("mid rst l3 state", dut_l3.state_q, StIdle);
    pixel_y = 10'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`ifdef SCREEN_FETCH_STATS_EN
    check("post rst underrun", 32'(underrun1), 32'd0);
`endif
    repeat (2) @(negedge clk);
    step_line(10'd1, 16'd0, 16'd1);
    step_line(10'd2, 16'd0, 16'd1);
    expect_word(10'd300, 16'hA001, 1'b1);
    expect_word(10'd530, 16'hA000, 1'b1);

    repeat (2) @(negedge clk);
    check("l1 requests outstanding", 32'(aq1.size()), 32'd0);
    check("l3 requests outstanding", 32'(aq3.size()), 32'd0);
    check("words outstanding", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_fetch.md
SCREEN_FETCH -- requirements
Module: screen_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, screen word width in bits.
REQ-002 SHALL have parameter BITS_PER_MEMORY_PIXEL_X, default 4, log2 horizontal pixels per binary-displayed bit.
REQ-003 SHALL have parameter BITS_PER_MEMORY_PIXEL_Y, default 5, log2 lines per binary-displayed row.
REQ-004 SHALL have parameter HEX_START_X, default 512, first pixel column of the hex region.
REQ-005 SHALL have parameter HEX_DIGIT_HEIGHT, default 32, lines per hex row.
REQ-006 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-007 SHALL have parameter RAM_LATENCY, default 1, cycles from ram_addr to valid ram_rdata (1..3).
REQ-008 CLK_50  in  1  single clock for all logic.
REQ-009 resetN  in  1  reset, asynchronous, active-low.
REQ-010 pixel_x  in  10  current scan column from the VGA timing block.
REQ-011 pixel_y  in  10  current scan line.
REQ-012 ram_addr  out  DATA_WIDTH  screen-port word address to RAM.
REQ-013 ram_re  out  1  high for each cycle ram_addr is a live request.
REQ-014 ram_rdata  in  DATA_WIDTH  screen-port read data.
REQ-015 word_value  out  DATA_WIDTH  word covering (pixel_x, pixel_y), from line buffer.
REQ-016 word_valid  out  1  high when word_value comes from a completed fetch.

Function
REQ-017 SHALL derive BIN_WORDS = 512 >> (clog2(DATA_WIDTH)+BITS_PER_MEMORY_PIXEL_X) and HEX_WORDS = 2; LINE_WORDS = BIN_WORDS + HEX_WORDS.
REQ-018 SHALL hold a ping-pong line buffer of 2 x LINE_WORDS words; display bank read, fill bank written.
REQ-019 SHALL detect a new line as a cycle where pixel_y differs from its registered copy; that cycle swaps banks and starts a fetch for line N = pixel_y+1, wrapping to 0 when pixel_y+1 >= V_VISIBLE.
REQ-020 Fetch addresses, index i: binary i<BIN_WORDS -> (N>>BITS_PER_MEMORY_PIXEL_Y)*BIN_WORDS+i; hex j=i-BIN_WORDS -> (N/HEX_DIGIT_HEIGHT)*HEX_WORDS+j; truncated to DATA_WIDTH.
REQ-021 FSM states IDLE, ISSUE, DRAIN: IDLE->ISSUE on new line; ISSUE issues one address per cycle with ram_re=1 for LINE_WORDS cycles, then DRAIN; DRAIN waits RAM_LATENCY cycles capturing data, then IDLE.
REQ-022 Each ram_rdata SHALL be written to fill bank index i exactly RAM_LATENCY cycles after its request (delay pipe of index+valid).
REQ-023 A new-line event while not IDLE SHALL abort the fetch, mark that bank incomplete, swap, and restart from index 0.
REQ-024 word_value SHALL be registered (1-cycle latency from pixel_x/pixel_y): index pixel_x/PIXELS_PER_WORD in binary region, BIN_WORDS+(pixel_x-HEX_START_X)/(DATA_WIDTH/4*16) in hex region, clamped to LINE_WORDS-1.
REQ-025 word_valid SHALL be 1 only if the display bank's fetch completed; otherwise word_value SHALL be 0.
REQ-026 ram_re SHALL be 0 and ram_addr SHALL hold its last value outside ISSUE.

Reset
REQ-027 On resetN low: FSM IDLE, both banks incomplete, ram_re=0, ram_addr=0, word_value=0, word_valid=0, line-pipe cleared; buffer contents need not clear.
REQ-028 First new-line event after reset release SHALL start a fetch normally; first displayed line reads word_valid=0.

Configuration
REQ-029 Macro SCREEN_FETCH_STATS_EN defined: adds output underrun_count (16 bits, saturating) incremented on each abort per REQ-023, cleared by reset.
REQ-030 Macro undefined: port and counter absent; behaviour otherwise identical.

Structure
REQ-031 Shared package screen_pkg SHALL hold fetch FSM state typedef and derived constants BIN_WORDS, HEX_WORDS, LINE_WORDS, PIXELS_PER_WORD.
REQ-032 Line buffer SHALL be a sub-module line_buffer_pp (dual-bank, one write port, one read port, bank-select input).

Verification
REQ-033 Reset, pixel_y 0->1 step -> ram_re high 4 cycles, ram_addr 0,1,0,1 (line 2, defaults), DRAIN 1 cycle, IDLE.
REQ-034 RAM model word[k]=0xA000+k, pixel_y=63->64 -> fetch for line 65 addresses 4,5,4,5; after swap, pixel_x=300 -> word_value 0xA005, word_valid=1.
REQ-035 pixel_y=479->0 wrap -> fetch targets line 1, addresses 0,1,0,1.
REQ-036 Two new-line events 2 cycles apart -> first fetch aborted, second completes all 4 words; display bank of aborted line gives word_valid=0, word_value=0; with SCREEN_FETCH_STATS_EN, underrun_count=1.
REQ-037 RAM_LATENCY=3 -> each word stored 3 cycles after request; DRAIN lasts 3 cycles; buffer contents match model.
REQ-038 resetN low mid-ISSUE -> ram_re 0 immediately, word_valid 0, FSM IDLE; next line fetch completes normally.
